// File: rtl/lifo_pkg.sv
// Shared command encodings and controller state type for the lifo command path.
package lifo_pkg;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PEEK = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    POP_WAIT = 2'd1,
    PUSHBACK = 2'd2
  } lifo_ctrl_state_t;

endpackage

// File: rtl/lifo.sv
// Synchronous stack with one-cycle registered read; push/pop beyond the bounds are ignored.
module lifo #(
  parameter int LIFO_SIZE = 6,
  parameter int DATA_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout
);

  localparam int SP_W  = $clog2(LIFO_SIZE + 1);
  localparam int IDX_W = (LIFO_SIZE > 1) ? $clog2(LIFO_SIZE) : 1;
  localparam logic [SP_W-1:0] FULL = SP_W'(LIFO_SIZE);

  logic [DATA_W-1:0] mem [LIFO_SIZE];
  logic [SP_W-1:0]   sp_q;
  logic [DATA_W-1:0] dataout_q;

  logic do_push;
  logic do_pop;

  assign do_push = write && (sp_q < FULL);
  assign do_pop  = !write && read && (sp_q != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q      <= '0;
      dataout_q <= '0;
    end else if (do_push) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (do_pop) begin
      dataout_q <= mem[IDX_W'(sp_q - SP_W'(1))];
      sp_q      <= sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem[IDX_W'(sp_q)] <= datain;
    end
  end

  assign dataout = dataout_q;

endmodule

// File: rtl/lifo_ctrl.sv
// Push/pop/peek command controller for an attached lifo; LIFO_CTRL_PEEK_EN enables op 10 (peek)
// and the PUSHBACK state, otherwise op 10 is answered with an error response.
module lifo_ctrl
  import lifo_pkg::*;
#(
  parameter int LIFO_SIZE = 6,
  parameter int DATA_W    = 10,
  parameter int CNT_W     = $clog2(LIFO_SIZE + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  count,
  output logic              lifo_write,
  output logic              lifo_read,
  output logic [DATA_W-1:0] lifo_datain,
  input  logic [DATA_W-1:0] lifo_dataout
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(LIFO_SIZE);

  lifo_ctrl_state_t  state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_pass_q, rsp_pass_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] datain_q, datain_d;
  logic              reject;
`ifdef LIFO_CTRL_PEEK_EN
  logic              peek_q, peek_d;
  logic              wb_q, wb_d;
`endif

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_pass_d  = 1'b0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    datain_d    = '0;
    reject      = 1'b0;
`ifdef LIFO_CTRL_PEEK_EN
    peek_d      = peek_q;
    wb_d        = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_PUSH: begin
              if (count_q < FULL) begin
                wr_d        = 1'b1;
                datain_d    = cmd_data;
                count_d     = count_q + CNT_W'(1);
                rsp_valid_d = 1'b1;
              end else begin
                reject = 1'b1;
              end
            end
            OP_POP: begin
              if (count_q != '0) begin
                rd_d    = 1'b1;
                count_d = count_q - CNT_W'(1);
                state_d = POP_WAIT;
`ifdef LIFO_CTRL_PEEK_EN
                peek_d  = 1'b0;
`endif
              end else begin
                reject = 1'b1;
              end
            end
`ifdef LIFO_CTRL_PEEK_EN
            OP_PEEK: begin
              if (count_q != '0) begin
                rd_d    = 1'b1;
                peek_d  = 1'b1;
                state_d = POP_WAIT;
              end else begin
                reject = 1'b1;
              end
            end
`endif
            default: reject = 1'b1;
          endcase
        end
      end
      // lifo dataout becomes valid during the cycle after POP_WAIT; it is
      // forwarded from there rather than re-registered (see output muxes).
      POP_WAIT: begin
        rsp_valid_d = 1'b1;
        rsp_pass_d  = 1'b1;
        state_d     = IDLE;
`ifdef LIFO_CTRL_PEEK_EN
        if (peek_q) begin
          wr_d    = 1'b1;
          wb_d    = 1'b1;
          state_d = PUSHBACK;
        end
`endif
      end
`ifdef LIFO_CTRL_PEEK_EN
      PUSHBACK: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    if (reject) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_pass_q  <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      datain_q    <= '0;
`ifdef LIFO_CTRL_PEEK_EN
      peek_q      <= 1'b0;
      wb_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_pass_q  <= rsp_pass_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      datain_q    <= datain_d;
`ifdef LIFO_CTRL_PEEK_EN
      peek_q      <= peek_d;
      wb_q        <= wb_d;
`endif
    end
  end

  assign cmd_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign count      = count_q;
  assign lifo_write = wr_q;
  assign lifo_read  = rd_q;
  assign rsp_data   = rsp_pass_q ? lifo_dataout : '0;
`ifdef LIFO_CTRL_PEEK_EN
  assign lifo_datain = wb_q ? lifo_dataout : datain_q;
`else
  assign lifo_datain = datain_q;
`endif

endmodule

// File: doc/lifo_ctrl.md
# lifo_ctrl

Command-side controller that drives the team's `lifo` stack through its `write`/`read`/`datain`/`dataout` interface. Upstream logic issues push, pop and optional peek commands over a valid/ready handshake and receives one response pulse per command. The block tracks stack occupancy, rejects overflow and underflow with an error response, and sequences the stack's one-cycle read latency. It sits between the search engine and a `lifo` instance of matching `LIFO_SIZE`/`DATA_W`.

## Interface
- `LIFO_SIZE`, default 6: depth of the attached `lifo`, in entries.
- `DATA_W`, default 10: data width in bits.
- `CNT_W`, derived as `$clog2(LIFO_SIZE+1)`: occupancy width. Not to be overridden.
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high reset; the same net also drives the attached `lifo`.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the block accepts a command this cycle.
- `cmd_op` in 2: command code. 00 = push, 01 = pop, 10 = peek, 11 = reserved.
- `cmd_data` in DATA_W: push payload.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_data` out DATA_W: popped or peeked value. It is 0 for push and for any error.
- `rsp_err` out 1: qualifies `rsp_valid`; marks a rejected command.
- `count` out CNT_W: current stack occupancy.
- `lifo_write` out 1: drives `lifo.write`.
- `lifo_read` out 1: drives `lifo.read`.
- `lifo_datain` out DATA_W: drives `lifo.datain`.
- `lifo_dataout` in DATA_W: from `lifo.dataout`.

## Operation
- FSM states: IDLE, POP_WAIT, PUSHBACK.
- `cmd_ready` is 1 only in IDLE. A command is accepted at edge T when `cmd_valid & cmd_ready`.
- All outputs are registered.
- **Push, count < LIFO_SIZE:**
  - In cycle T+1: `lifo_write`=1, `lifo_datain`=`cmd_data`, `count`+1.
  - `rsp_valid`=1 and `rsp_err`=0 in the same cycle. State stays IDLE.
- **Pop, count > 0:**
  - Cycle T+1: `lifo_read`=1, `count`-1, state goes to POP_WAIT.
  - Cycle T+2: `rsp_valid`=1, `rsp_data`=`lifo_dataout`, then back to IDLE.
- **Peek, count > 0, only with the macro defined:**
  - Cycle T+1: `lifo_read`=1, state goes to POP_WAIT.
  - Cycle T+2: `lifo_write`=1, `lifo_datain`=`lifo_dataout`, `rsp_valid`=1, `rsp_data`=`lifo_dataout`, state goes to PUSHBACK.
  - Cycle T+3: back to IDLE.
  - `count` is unchanged overall.
- **Error cases:** push when full, pop or peek when empty, op 11, and op 10 without the macro.
  - In cycle T+1: `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0.
  - No `lifo_read` or `lifo_write`, and `count` is unchanged.
- `lifo_write` and `lifo_read` are never asserted in the same cycle.
- `count` never exceeds LIFO_SIZE and never wraps below 0.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0, `count`=0, `lifo_write`=0, `lifo_read`=0, `lifo_datain`=0.
- Commands presented while `reset`=1 are ignored.
- Reset mid-command, in POP_WAIT or PUSHBACK:
  - The operation is abandoned, with no response and `count`=0.
  - The `lifo` is reset in the same cycle, so the two stay consistent.
- Latency from acceptance to response:
  - push: 1 cycle.
  - pop: 2 cycles.
  - peek: 2 cycles.
  - error: 1 cycle.
- Throughput:
  - push: one per cycle, since `cmd_ready` stays high.
  - pop: one per 2 cycles.
  - peek: one per 3 cycles.
- There is no response backpressure; the consumer must take `rsp_valid` when it pulses.

## Configuration
- Macro: `LIFO_CTRL_PEEK_EN`.
- Defined: op 10 performs a peek as a pop followed by a push-back, and the PUSHBACK state exists.
- Undefined: op 10 returns an error response, and PUSHBACK is not synthesized.

## Structure
- `lifo_pkg` holds:
  - the op encodings `OP_PUSH`, `OP_POP`, `OP_PEEK`, `OP_RSVD`;
  - the FSM state enum `lifo_ctrl_state_t`.
- No sub-module. The occupancy counter and FSM live inline.
- The bench instantiates `lifo_ctrl` together with `lifo` (same parameters, shared `clk`/`reset`).

## Test plan
- Push 0x011, 0x022, 0x033 back-to-back, then pop three times. Responses are 0x033, 0x022, 0x011, each at T+2 with `rsp_err`=0; `count` goes 3 to 0.
- Pop after reset: `rsp_err`=1 at T+1, `rsp_data`=0, no `lifo_read`, `count`=0.
- Push 6 values, then push 0x3FF: `rsp_err`=1, no `lifo_write`, `count` stays 6.
- With `LIFO_CTRL_PEEK_EN`: push 0x155, peek (returns 0x155, `count`=1), then pop (returns 0x155, `count`=0). Without the macro, the same peek gives `rsp_err`=1.
- Push 0x0AA, start a pop, and assert `reset` in POP_WAIT: no `rsp_valid`, `count`=0, `cmd_ready`=1 in the next cycle.
- Hold `cmd_valid` with op pop across 4 cycles: `cmd_ready` pattern is 1,0,1,0, and exactly two pops are accepted.
